// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed, LSB-first shifter with optional parity
// and 1 or 2 stop bits, emitting back-to-back frames while words are queued.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_rdy,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 ovf,
  output logic                 TX
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
  localparam logic          STOP_LAST  = (STOP_BITS == 32'sd2);
  localparam logic          HAS_PARITY = (PARITY != 32'sd0);
  localparam logic          ODD_PARITY = (PARITY == 32'sd1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity of the popped word: odd makes data+parity carry an odd number of ones.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    logic ones_odd;
    ones_odd = ^word;
    if (ODD_PARITY) begin
      return ~ones_odd;
    end else begin
      return ones_odd;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        count_nxt_s;

  state_t               state_r;
  logic [BW-1:0]        baud_cnt_r;
  logic [3:0]           bit_cnt_r;
  logic                 stop_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_r;

  logic tx_r;
  logic tx_rdy_r;
  logic tx_busy_r;
  logic tx_done_r;
  logic ovf_r;

  logic                 push_s;
  logic                 drop_s;
  logic                 pop_s;
  logic                 baud_end_s;
  logic                 frame_end_s;
  logic                 idle_nxt_s;
  logic [DATA_BITS-1:0] head_s;

  // FIFO handshake and FSM event decode, all from pre-edge state.
  always_comb begin
    head_s      = mem_r[rd_ptr_r];
    baud_end_s  = (baud_cnt_r == BAUD_LAST);
    frame_end_s = (state_r == ST_STOP) && baud_end_s && (stop_cnt_r == STOP_LAST);
    push_s      = trmt && (count_r != FIFO_FULL);
    drop_s      = trmt && (count_r == FIFO_FULL);
    pop_s       = (count_r != '0) && ((state_r == ST_IDLE) || frame_end_s);
    idle_nxt_s  = !pop_s && ((state_r == ST_IDLE) || frame_end_s);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset since only written entries are read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the status flags derived from them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      tx_rdy_r  <= 1'b1;
      tx_busy_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r   <= count_nxt_s;
      tx_rdy_r  <= (count_nxt_s != FIFO_FULL);
      tx_busy_r <= !(idle_nxt_s && (count_nxt_s == '0));
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Frame sequencer: every bit is held BAUD_DIV clocks, advancing on the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= '0;
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= '0;
          if (pop_s) begin
            shift_r  <= head_s;
            parity_r <= parity_bit(head_s);
            state_r  <= ST_START;
            tx_r     <= 1'b0;
          end else begin
            tx_r <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (bit_cnt_r == DATA_LAST) begin
              if (HAS_PARITY) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r       <= 1'b1;
                stop_cnt_r <= 1'b0;
                state_r    <= ST_STOP;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        ST_PARITY: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= ST_STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_end_s) begin
            baud_cnt_r <= '0;
            if (stop_cnt_r == STOP_LAST) begin
              tx_done_r <= 1'b1;
              // A queued word starts its START bit on this same edge.
              if (pop_s) begin
                shift_r  <= head_s;
                parity_r <= parity_bit(head_s);
                state_r  <= ST_START;
                tx_r     <= 1'b0;
              end else begin
                state_r <= ST_IDLE;
                tx_r    <= 1'b1;
              end
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= '0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  assign TX      = tx_r;
  assign tx_rdy  = tx_rdy_r;
  assign tx_busy = tx_busy_r;
  assign tx_done = tx_done_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations checked every cycle against a
// frame-offset model, plus directed literal expectations.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] trmt_v;
  logic [8:0] data_v [4];
  logic [3:0] tx_v, rdy_v, busy_v, done_v, ovf_v;

  localparam int DB_P  [4] = '{8, 8, 8, 9};
  localparam int BD_P  [4] = '{16, 16, 16, 4};
  localparam int PAR_P [4] = '{0, 2, 1, 0};
  localparam int SB_P  [4] = '{1, 1, 2, 1};

  uart_tx_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .trmt(trmt_v[0]), .tx_data(data_v[0][7:0]), .tx_rdy(rdy_v[0]),
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .ovf(ovf_v[0]), .TX(tx_v[0]));
  uart_tx_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .trmt(trmt_v[1]), .tx_data(data_v[1][7:0]), .tx_rdy(rdy_v[1]),
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .ovf(ovf_v[1]), .TX(tx_v[1]));
  uart_tx_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .trmt(trmt_v[2]), .tx_data(data_v[2][7:0]), .tx_rdy(rdy_v[2]),
    .tx_busy(busy_v[2]), .tx_done(done_v[2]), .ovf(ovf_v[2]), .TX(tx_v[2]));
  uart_tx_param #(.DATA_BITS(9), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst(rst), .trmt(trmt_v[3]), .tx_data(data_v[3]), .tx_rdy(rdy_v[3]),
    .tx_busy(busy_v[3]), .tx_done(done_v[3]), .ovf(ovf_v[3]), .TX(tx_v[3]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit model_valid = 1'b0;

  int mq [4][$];
  bit mact [4];
  int mstart [4];
  int mword [4];
  bit exp_tx [4], exp_rdy [4], exp_busy [4], exp_done [4], exp_ovf [4];

  int done_cnt [4] = '{0, 0, 0, 0};
  int last_done [4] = '{0, 0, 0, 0};
  int done0_q [$];

  function automatic int flen(input int i);
    return (1 + DB_P[i] + ((PAR_P[i] != 0) ? 1 : 0) + SB_P[i]) * BD_P[i];
  endfunction

  // Line level at a given clock offset into a frame, from the frame layout.
  function automatic bit frame_bit(input int i, input int word, input int off);
    int b;
    int ones;
    b = off / BD_P[i];
    if (b == 0) return 1'b0;
    if (b <= DB_P[i]) return ((word >> (b - 1)) & 1) != 0;
    if (PAR_P[i] != 0 && b == DB_P[i] + 1) begin
      ones = $countones(word);
      return (PAR_P[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) check("wait_target", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int i, input int w, output int k);
    data_v[i] = 9'(w);
    trmt_v[i] = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    trmt_v[i] = 1'b0;
  endtask

  // Model: advance on each rising edge using the pre-edge inputs.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst === 1'b1) begin
      model_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        mact[i] = 1'b0;
        exp_tx[i] = 1'b1; exp_rdy[i] = 1'b1; exp_busy[i] = 1'b0;
        exp_done[i] = 1'b0; exp_ovf[i] = 1'b0;
      end
    end else if (model_valid) begin
      for (int i = 0; i < 4; i++) begin
        int pre;
        pre = mq[i].size();
        exp_done[i] = 1'b0;
        if (mact[i] && (cyc - mstart[i] == flen(i))) begin
          exp_done[i] = 1'b1;
          mact[i] = 1'b0;
        end
        if (!mact[i] && pre > 0) begin
          mword[i] = mq[i].pop_front();
          mact[i] = 1'b1;
          mstart[i] = cyc;
        end
        if (trmt_v[i] === 1'b1) begin
          if (pre == 4) exp_ovf[i] = 1'b1;
          else mq[i].push_back(int'(data_v[i]) & ((1 << DB_P[i]) - 1));
        end
        exp_tx[i]   = mact[i] ? frame_bit(i, mword[i], cyc - mstart[i]) : 1'b1;
        exp_rdy[i]  = (mq[i].size() != 4);
        exp_busy[i] = mact[i] || (mq[i].size() != 0);
      end
    end
  end

  // Compare every output of every instance on the falling edge.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("tx[%0d]", i), 32'(tx_v[i]), 32'(exp_tx[i]));
        check($sformatf("tx_rdy[%0d]", i), 32'(rdy_v[i]), 32'(exp_rdy[i]));
        check($sformatf("tx_busy[%0d]", i), 32'(busy_v[i]), 32'(exp_busy[i]));
        check($sformatf("tx_done[%0d]", i), 32'(done_v[i]), 32'(exp_done[i]));
        check($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(exp_ovf[i]));
        if (done_v[i] === 1'b1) begin
          done_cnt[i]++;
          last_done[i] = cyc;
          if (i == 0) done0_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int k, kk, d;
    logic [9:0] seq77;
    seq77 = 10'b1011101110;
    rst = 1'b1;
    trmt_v = 4'h0;
    for (int i = 0; i < 4; i++) data_v[i] = 9'h000;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx_v), 32'hF);
    check("reset_rdy", 32'(rdy_v), 32'hF);
    check("reset_busy", 32'(busy_v), 32'h0);
    check("reset_done", 32'(done_v), 32'h0);
    check("reset_ovf", 32'(ovf_v), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 frame of 0x77
    push(0, 32'h77, k);
    check("t1_idle_at_k", 32'(tx_v[0]), 32'h1);
    for (int j = 0; j < 10; j++) begin
      wait_cyc(k + 1 + 16 * j + 8);
      check("t1_bit", 32'(tx_v[0]), 32'(seq77[j]));
    end
    wait_cyc(k + 161);
    check("t1_done_pulse", 32'(done_v[0]), 32'h1);
    check("t1_busy_drop", 32'(busy_v[0]), 32'h0);
    wait_cyc(k + 165);
    check("t1_done_edge", last_done[0], k + 161);
    check("t1_done_count", done_cnt[0], 1);

    // even parity on 0x55
    push(1, 32'h55, k);
    wait_cyc(k + 1 + 16 * 9 + 8);
    check("t2_parity_bit", 32'(tx_v[1]), 32'h0);
    wait_cyc(k + 185);
    check("t2_frame_len", last_done[1] - (k + 1), 176);

    // odd parity with two stop bits on 0xCC
    push(2, 32'hCC, k);
    wait_cyc(k + 1 + 16 * 9 + 8);
    check("t3_parity_bit", 32'(tx_v[2]), 32'h1);
    wait_cyc(k + 1 + 160);
    check("t3_stop_first", 32'(tx_v[2]), 32'h1);
    wait_cyc(k + 192);
    check("t3_stop_last", 32'(tx_v[2]), 32'h1);
    check("t3_no_early_done", 32'(done_v[2]), 32'h0);
    wait_cyc(k + 200);
    check("t3_done_edge", last_done[2], k + 193);

    // three back-to-back frames
    done0_q.delete();
    push(0, 32'h11, k);
    push(0, 32'h22, kk);
    push(0, 32'h33, kk);
    wait_cyc(k + 500);
    check("t4_done_count", done0_q.size(), 3);
    check("t4_first_done", done0_q[0], k + 161);
    check("t4_spacing_1", done0_q[1] - done0_q[0], 160);
    check("t4_spacing_2", done0_q[2] - done0_q[1], 160);

    // overflow: six pushes into a depth-4 FIFO
    d = done_cnt[0];
    for (int j = 0; j < 6; j++) begin
      push(0, j + 1, kk);
      if (j == 0) k = kk;
    end
    check("t5_rdy_full", 32'(rdy_v[0]), 32'h0);
    check("t5_ovf_set", 32'(ovf_v[0]), 32'h1);
    wait_cyc(k + 821);
    check("t5_frames", done_cnt[0] - d, 5);
    check("t5_ovf_sticky", 32'(ovf_v[0]), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ovf_cleared", 32'(ovf_v[0]), 32'h0);

    // reset during data bit 3 of 0xA5 with two words queued
    push(0, 32'hA5, k);
    push(0, 32'h5A, kk);
    push(0, 32'h3C, kk);
    wait_cyc(k + 70);
    check("t6_mid_bit3", 32'(tx_v[0]), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_tx_high", 32'(tx_v[0]), 32'h1);
    check("t6_busy", 32'(busy_v[0]), 32'h0);
    check("t6_rdy", 32'(rdy_v[0]), 32'h1);
    check("t6_ovf", 32'(ovf_v[0]), 32'h0);
    d = done_cnt[0];
    wait_cyc(cyc + 600);
    check("t6_no_frames", done_cnt[0], d);
    check("t6_tx_idle", 32'(tx_v[0]), 32'h1);

    // nine data bits at four clocks per bit
    push(3, 32'h1FF, k);
    wait_cyc(k + 1 + 2);
    check("t7_start", 32'(tx_v[3]), 32'h0);
    for (int j = 1; j <= 9; j++) begin
      wait_cyc(k + 1 + 4 * j + 2);
      check("t7_data", 32'(tx_v[3]), 32'h1);
    end
    wait_cyc(k + 50);
    check("t7_frame_len", last_done[3] - (k + 1), 44);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the team's fixed 8N1 UART transmitter. It serialises DATA_BITS-wide words LSB-first with optional parity and 1 or 2 stop bits, at a fixed BAUD_DIV clocks per bit. A small FIFO in front of the shifter accepts words while a frame is in progress, so frames go out back-to-back with no idle gap. It sits between command/telemetry logic and the board-level TX pin.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9
BAUD_DIV, 2604, clocks per bit period; minimum 4
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, word entries; power of 2, minimum 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
trmt  input  1  push strobe; tx_data is sampled on any edge where trmt=1
tx_data  input  DATA_BITS  word to transmit
tx_rdy  output  1  FIFO not full
tx_busy  output  1  frame in progress or FIFO non-empty
tx_done  output  1  one-cycle pulse at the end of each frame
ovf  output  1  sticky: a push was dropped because the FIFO was full
TX  output  1  serial line; idles high

Behaviour:
- Reset is synchronous and active-high; clock is clk.
- Reset values: TX=1, tx_rdy=1, tx_busy=0, tx_done=0, ovf=0. FIFO is emptied; baud and bit counters are zero; state is IDLE.
- rst asserted mid-frame: TX=1 after that edge, and the queued words are discarded.
- FIFO push: at edge k with trmt=1 and count<FIFO_DEPTH, tx_data is written.
- Full check uses the pre-edge count. A push while full is dropped and sets ovf, even if a pop occurs on the same edge.
- ovf clears only on rst.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty: pop the head into the shift register, go to START, drive TX=0. All of this happens on the same edge.
- Latency: trmt at edge k into an empty FIFO in IDLE gives TX=0 from edge k+1.
- Baud counter runs 0..BAUD_DIV-1. Every bit is held exactly BAUD_DIV clocks. The state/bit advance happens on the edge where the count is BAUD_DIV-1.
- START -> DATA: DATA_BITS bits, LSB first, shift right.
- After DATA: go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY bit:
  - odd: the bit makes the total count of ones in data+parity odd.
  - even: the bit makes that total even.
  - It is computed from the popped word.
- STOP: TX=1 for STOP_BITS*BAUD_DIV clocks.
- Frame length is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV clocks exactly.
- End of STOP, FIFO non-empty: on that edge, tx_done=1 for one cycle. On the same edge, the next word is popped and TX=0 (START), giving zero idle clocks between frames.
- End of STOP, FIFO empty: tx_done pulses and the state goes to IDLE with TX=1.
- tx_busy=0 only in IDLE with the FIFO empty. tx_rdy is a registered or combinational decode of the count; it must be valid in the same cycle the count changes.
- Push and pop on the same edge with the FIFO neither full nor empty: count is unchanged and the data order is preserved.
- The FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Changes to tx_data while the FIFO holds it have no effect on the frame.

Test Plan:
- Reset, then push 0x77 at edge k (DATA_BITS=8, PARITY=0, STOP_BITS=1, BAUD_DIV=16) -> TX low at k+1; line sequence 0,1,1,1,0,1,1,1,0,1 with each bit 16 clocks; tx_done pulses once at k+161; tx_busy drops the same cycle.
- PARITY=2, push 0x55 -> the 8 data bits are followed by parity 0, then stop; total frame is 176 clocks.
- PARITY=1, STOP_BITS=2, push 0xCC -> parity bit 1, then TX high for 32 clocks before tx_done.
- Push 0x11, 0x22, 0x33 on consecutive clocks -> three frames in order with no idle clock between STOP and the next START; three tx_done pulses spaced 160 clocks apart.
- FIFO_DEPTH=4, push 6 words on consecutive clocks while IDLE -> the first is popped immediately; 4 are queued and tx_rdy=0; the 6th is dropped and ovf=1; exactly 5 frames are sent; ovf stays 1 until rst.
- Assert rst for one clock during DATA bit 3 of 0xA5, with 2 words queued -> TX=1 next cycle, tx_busy=0, tx_rdy=1, ovf=0; no further frames are sent.
- Reset with DATA_BITS=9, BAUD_DIV=4, then push 0x1FF (no other traffic) -> 9 ones LSB-first, then stop; frame is 44 clocks.
